// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: groups the operand/result handshakes and the shared ALU
// drive/return lines of the multiply sequencer.
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; valid, once raised, holds its payload stable until
// that edge, and ready never depends combinationally on valid.
interface alu_mul_seq_if #(
   parameter int WORD_SIZE = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WORD_SIZE-1:0] in_a;
   logic [WORD_SIZE-1:0] in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [WORD_SIZE-1:0] out_result;
   logic [WORD_SIZE-1:0] alu_arg_a;
   logic [WORD_SIZE-1:0] alu_arg_b;
   logic [3:0]           alu_sel;
   logic [WORD_SIZE-1:0] alu_result;

   // Sequencer side.
   modport slave (
      input  in_valid, in_a, in_b, out_ready, alu_result,
      output in_ready, out_valid, out_result, alu_arg_a, alu_arg_b, alu_sel
   );

   // Requester / consumer / ALU side.
   modport master (
      output in_valid, in_a, in_b, out_ready, alu_result,
      input  in_ready, out_valid, out_result, alu_arg_a, alu_arg_b, alu_sel
   );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle shift-and-add multiplier that borrows the shared
// combinational ALU for one ADD per clock while busy. Produces the low
// WORD_SIZE bits of in_a*in_b (same bits for signed and unsigned operands).
// Optional build macro MUL_EARLY_EXIT_EN: leave RUN as soon as no multiplier
// bits remain above bit 0, giving a RUN length set by the highest set bit.
// o_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE) for observation.
module alu_mul_seq #(
   parameter int WORD_SIZE = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_mul_seq_if.slave        bus,
   output logic [1:0]          o_state
);
   localparam int CW = $clog2(WORD_SIZE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WORD_SIZE-1:0] r_acc;
   logic [WORD_SIZE-1:0] r_mcand;
   logic [WORD_SIZE-1:0] r_mplier;
   logic [WORD_SIZE-1:0] r_result;
   logic [CW-1:0]        r_count;
   logic                 w_run_last;

   // Decide whether the current RUN cycle is the final shift-add step.
   always_comb begin
`ifdef MUL_EARLY_EXIT_EN
      w_run_last = (r_count == CW'(WORD_SIZE - 1)) || ((r_mplier >> 1) == '0);
`else
      w_run_last = (r_count == CW'(WORD_SIZE - 1));
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; in_valid outside IDLE and out_ready outside DONE are ignored.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid) w_next = S_RUN;
         S_RUN:   if (w_run_last)   w_next = S_DONE;
         S_DONE:  if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state only (ALU owned only during RUN).
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.alu_sel   = 4'h0;
      bus.alu_arg_a = '0;
      bus.alu_arg_b = '0;
      case (r_state)
         S_IDLE: bus.in_ready = rst_n;
         S_RUN: begin
            bus.alu_sel   = 4'h1;
            bus.alu_arg_a = r_acc;
            bus.alu_arg_b = r_mplier[0] ? r_mcand : '0;
         end
         S_DONE:  bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: load operands, one shift-add per RUN cycle, latch the product.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_acc    <= '0;
                  r_mcand  <= bus.in_a;
                  r_mplier <= bus.in_b;
                  r_count  <= '0;
               end
            end
            S_RUN: begin
               r_acc    <= bus.alu_result;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               if (w_run_last) r_result <= bus.alu_result;
            end
            S_DONE: begin
               if (bus.out_ready) r_result <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_result = r_result;
   assign o_state        = r_state;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench for alu_mul_seq with a behavioural ALU.
module tb_alu_mul_seq;
   localparam int W = 32;
   localparam logic [1:0] ST_IDLE = 2'd0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] state;
   int         cyc_cnt = 0;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_q[$];

   alu_mul_seq_if #(.WORD_SIZE(W)) bus ();

   alu_mul_seq #(.WORD_SIZE(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .o_state(state)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt = cyc_cnt + 1;

   // Shared combinational ALU: ADD on select 1, zero otherwise.
   assign bus.alu_result = (bus.alu_sel == 4'h1) ? (bus.alu_arg_a + bus.alu_arg_b) : '0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles from acceptance (accepting cycle counted as 1) to first out_valid.
   function automatic int exp_lat(input logic [W-1:0] b);
      int h;
      h = 0;
`ifdef MUL_EARLY_EXIT_EN
      for (int i = 0; i < W; i++) if (b[i]) h = i + 1;
      if (h == 0) h = 1;
`else
      h = W;
`endif
      return h + 1;
   endfunction

   // Present one operand pair, wait for the product, check result/latency/ALU use.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string tag);
      int cyc;
      logic bad_sel;
      logic [W-1:0] e;
      cyc = 0;
      while (!bus.in_ready && cyc < 100) begin
         tick();
         cyc++;
      end
      check({tag, "_in_ready"}, W'(bus.in_ready), 1);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      exp_q.push_back(exp);
      tick();
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      cyc     = 1;
      bad_sel = 1'b0;
      while (!bus.out_valid && cyc < 200) begin
         if (bus.alu_sel != 4'h1) bad_sel = 1'b1;
         tick();
         cyc++;
      end
      check({tag, "_latency"}, W'(cyc), W'(exp_lat(b)));
      check({tag, "_sel_run"}, W'(bad_sel), 0);
      check({tag, "_sel_done"}, W'(bus.alu_sel), 0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check({tag, "_result"}, bus.out_result, e);
   endtask

   logic [W-1:0] ha[3];
   logic [W-1:0] hb[3];
   logic [W-1:0] he[3];
   int           t_out[3];

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      // Reset.
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_in_ready_low", W'(bus.in_ready), 0);
      check("rst_out_valid", W'(bus.out_valid), 0);
      check("rst_alu_sel", W'(bus.alu_sel), 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready_high", W'(bus.in_ready), 1);
      check("rst_state", W'(state), W'(ST_IDLE));
      check("rst_out_result", bus.out_result, 0);

      // out_ready while idle is ignored.
      bus.out_ready = 1'b1;
      tick();
      check("idle_out_valid", W'(bus.out_valid), 0);

      run_op(32'd3, 32'd5, 32'd15, "mul_3x5");
      tick();
      check("mul_3x5_back_idle", W'(state), W'(ST_IDLE));
      check("mul_3x5_in_ready", W'(bus.in_ready), 1);
      check("mul_3x5_cleared", bus.out_result, 0);

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_m1xm1");
      tick();
      run_op(32'h8000_0000, 32'd2, 32'h0000_0000, "mul_wrap");
      tick();
      run_op(32'h0000_1234, 32'd0, 32'h0000_0000, "mul_b0");
      tick();

      // Backpressure in DONE.
      bus.out_ready = 1'b0;
      run_op(32'd6, 32'd7, 32'd42, "mul_6x7");
      begin
         logic bad;
         bad = 1'b0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.out_valid || bus.out_result != 32'd42 || bus.in_ready) bad = 1'b1;
         end
         check("bp_hold_stable", W'(bad), 0);
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_state", W'(state), W'(ST_IDLE));
      check("bp_release_in_ready", W'(bus.in_ready), 1);
      check("bp_release_out_valid", W'(bus.out_valid), 0);

      // Reset in RUN cycle 10 discards the operation.
      bus.in_a     = 32'd9;
      bus.in_b     = 32'h8000_0009;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (9) tick();
      check("midrst_running", W'(bus.alu_sel), 1);
      rst_n = 1'b0;
      tick();
      check("midrst_state", W'(state), W'(ST_IDLE));
      check("midrst_in_ready_low", W'(bus.in_ready), 0);
      check("midrst_out_valid", W'(bus.out_valid), 0);
      check("midrst_out_result", bus.out_result, 0);
      check("midrst_alu_sel", W'(bus.alu_sel), 0);
      check("midrst_alu_args", bus.alu_arg_a | bus.alu_arg_b, 0);
      rst_n = 1'b1;
      #1;
      check("midrst_in_ready_high", W'(bus.in_ready), 1);
      run_op(32'd2, 32'd2, 32'd4, "mul_2x2");
      tick();

      // in_valid held high across three operand pairs.
      ha[0] = 32'd7;         hb[0] = 32'h8000_0003; he[0] = 32'h8000_0015;
      ha[1] = 32'd5;         hb[1] = 32'h8000_0001; he[1] = 32'h8000_0005;
      ha[2] = 32'hFFFF_FFFF; hb[2] = 32'h8000_0000; he[2] = 32'h8000_0000;
      fork
         begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
               int w;
               bus.in_a = ha[i];
               bus.in_b = hb[i];
               w = 0;
               while (!bus.in_ready && w < 200) begin
                  tick();
                  w++;
               end
               exp_q.push_back(he[i]);
               tick();
            end
            bus.in_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 3; k++) begin
               int w;
               logic [W-1:0] e;
               w = 0;
               while (!bus.out_valid && w < 300) begin
                  tick();
                  w++;
               end
               e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
               check($sformatf("held_result_%0d", k), bus.out_result, e);
               t_out[k] = cyc_cnt;
               tick();
            end
         end
      join
      check("held_spacing_01", W'(t_out[1] - t_out[0]), W'(W + 2));
      check("held_spacing_12", W'(t_out[2] - t_out[1]), W'(W + 2));
      check("queue_empty", W'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
